// File: rtl/pll_adda_lock_ctrl.sv
// ADDA PLL bring-up/supervision: reset sequencing, loop-filter profile retries, lock qualification.
// Optional lock-loss counter output enabled by defining PLL_ADDA_LOCK_LOSS_CNT_EN.
module pll_adda_lock_ctrl #(
  parameter int unsigned RST_CYCLES   = 100,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned MAX_RETRY    = 8
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       restart,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] icpsel,
  output logic [2:0] lpfres,
  output logic [1:0] lpfcap,
  output logic       locked,
`ifdef PLL_ADDA_LOCK_LOSS_CNT_EN
  output logic [7:0] lock_loss_cnt,
`endif
  output logic       fail,
  output logic [1:0] profile_idx,
  output logic [3:0] retry_cnt
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(LOCK_TIMEOUT);
  localparam logic [SW-1:0] STB_MAX  = SW'(LOCK_STABLE);

  typedef enum logic [1:0] {S_RST, S_WAIT, S_LOCKED, S_FAIL} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          lock_s;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [SW-1:0] stb_cnt_q, stb_cnt_d;
  logic          pll_reset_q, pll_reset_d;
  logic          locked_q, locked_d;
  logic          fail_q, fail_d;
  logic [1:0]    profile_q, profile_d;
  logic [3:0]    retry_q, retry_d;
  logic [10:0]   lf_q;

  assign lock_s = sync_q[1];

  function automatic logic [10:0] lf_tbl(input logic [1:0] p);
    case (p)
      2'd0:    lf_tbl = {6'd16, 3'd2, 2'd0};
      2'd1:    lf_tbl = {6'd24, 3'd3, 2'd0};
      2'd2:    lf_tbl = {6'd32, 3'd4, 2'd1};
      default: lf_tbl = {6'd8,  3'd1, 2'd0};
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = '0;
    to_cnt_d    = '0;
    stb_cnt_d   = '0;
    pll_reset_d = pll_reset_q;
    locked_d    = locked_q;
    fail_d      = fail_q;
    profile_d   = profile_q;
    retry_d     = retry_q;
    case (state_q)
      S_RST: begin
        pll_reset_d = 1'b1;
        locked_d    = 1'b0;
        fail_d      = 1'b0;
        if (rst_cnt_q >= RST_LAST) begin
          state_d     = S_WAIT;
          pll_reset_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        pll_reset_d = 1'b0;
        to_cnt_d    = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
        if (lock_s) stb_cnt_d = (stb_cnt_q == STB_MAX) ? stb_cnt_q : stb_cnt_q + 1'b1;
        // Lock qualification takes precedence over a coincident timeout.
        if (stb_cnt_q == STB_MAX) begin
          state_d  = S_LOCKED;
          locked_d = 1'b1;
          retry_d  = '0;
        end else if (to_cnt_q == TO_MAX) begin
          retry_d     = retry_q + 4'd1;
          profile_d   = profile_q + 2'd1;
          pll_reset_d = 1'b1;
          if (retry_d == 4'(MAX_RETRY)) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d = S_RST;
          end
        end
      end
      S_LOCKED: begin
        pll_reset_d = 1'b0;
        if (!lock_s) begin
          state_d     = S_RST;
          locked_d    = 1'b0;
          pll_reset_d = 1'b1;
        end
      end
      default: begin
        pll_reset_d = 1'b1;
        fail_d      = 1'b1;
        locked_d    = 1'b0;
      end
    endcase
    if (state_d != state_q) begin
      rst_cnt_d = '0;
      to_cnt_d  = '0;
      stb_cnt_d = '0;
    end
    if (restart) begin
      state_d     = S_RST;
      profile_d   = '0;
      retry_d     = '0;
      fail_d      = 1'b0;
      locked_d    = 1'b0;
      pll_reset_d = 1'b1;
      rst_cnt_d   = '0;
      to_cnt_d    = '0;
      stb_cnt_d   = '0;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= S_RST;
      sync_q      <= '0;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      stb_cnt_q   <= '0;
      pll_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      profile_q   <= '0;
      retry_q     <= '0;
      lf_q        <= lf_tbl(2'd0);
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[0], pll_lock};
      rst_cnt_q   <= rst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      pll_reset_q <= pll_reset_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      profile_q   <= profile_d;
      retry_q     <= retry_d;
      // Loop-filter settings only move while the PLL is held in reset.
      if (pll_reset_q) lf_q <= lf_tbl(profile_q);
    end
  end

`ifdef PLL_ADDA_LOCK_LOSS_CNT_EN
  logic [7:0] loss_q;
  always_ff @(posedge clkin) begin
    if (reset) loss_q <= '0;
    else if (state_q == S_LOCKED && !lock_s && !restart && loss_q != 8'hFF)
      loss_q <= loss_q + 8'd1;
  end
  assign lock_loss_cnt = loss_q;
`endif

  assign pll_reset   = pll_reset_q;
  assign locked      = locked_q;
  assign fail        = fail_q;
  assign profile_idx = profile_q;
  assign retry_cnt   = retry_q;
  assign {icpsel, lpfres, lpfcap} = lf_q;
endmodule

// File: tb/tb_pll_adda_lock_ctrl.sv
// Directed bench for pll_adda_lock_ctrl with shortened timing parameters.
module tb_pll_adda_lock_ctrl;
  localparam int RC = 4, LT = 64, LS = 8, MR = 3;

  logic clkin = 1'b0, reset = 1'b1, restart = 1'b0, pll_lock = 1'b0;
  logic pll_reset, locked, fail;
  logic [5:0] icpsel;
  logic [2:0] lpfres;
  logic [1:0] lpfcap, profile_idx;
  logic [3:0] retry_cnt;
`ifdef PLL_ADDA_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif
  int n_chk = 0, n_fail = 0;

  pll_adda_lock_ctrl #(.RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS), .MAX_RETRY(MR)) dut (
    .clkin(clkin), .reset(reset), .restart(restart), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .icpsel(icpsel), .lpfres(lpfres), .lpfcap(lpfcap),
    .locked(locked),
`ifdef PLL_ADDA_LOCK_LOSS_CNT_EN
    .lock_loss_cnt(lock_loss_cnt),
`endif
    .fail(fail), .profile_idx(profile_idx), .retry_cnt(retry_cnt));

  always #5 clkin = ~clkin;

  task automatic step();
    @(negedge clkin);
  endtask

  task automatic test_reset();
    reset = 1'b1; restart = 1'b0; pll_lock = 1'b0;
    repeat (3) step();
    n_chk++; if ({pll_reset, locked, fail} !== 3'b100) begin n_fail++; $display("FAIL reset_flags got %b want 100", {pll_reset, locked, fail}); end
    n_chk++; if ({icpsel, lpfres, lpfcap} !== {6'd16, 3'd2, 2'd0}) begin n_fail++; $display("FAIL reset_lf got %0d/%0d/%0d want 16/2/0", icpsel, lpfres, lpfcap); end
    n_chk++; if ({retry_cnt, profile_idx} !== 6'd0) begin n_fail++; $display("FAIL reset_cnt got retry %0d prof %0d want 0/0", retry_cnt, profile_idx); end
`ifdef PLL_ADDA_LOCK_LOSS_CNT_EN
    n_chk++; if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_loss got %0d want 0", lock_loss_cnt); end
`endif
    reset = 1'b0;
    for (int i = 1; i <= RC; i++) begin
      step();
      n_chk++; if (pll_reset !== 1'(i < RC)) begin n_fail++; $display("FAIL rst_len cyc %0d got %b want %b", i, pll_reset, 1'(i < RC)); end
      n_chk++; if ({icpsel, lpfres, lpfcap} !== {6'd16, 3'd2, 2'd0}) begin n_fail++; $display("FAIL rst_lf cyc %0d got %0d/%0d/%0d want 16/2/0", i, icpsel, lpfres, lpfcap); end
    end
  endtask

  task automatic test_lock();
    int n;
    repeat (10) step();
    pll_lock = 1'b1;
    n = 0;
    do begin step(); n++; end while (!locked && n < 40);
    n_chk++; if (n != 1 + 2 + LS) begin n_fail++; $display("FAIL lock_latency got %0d want %0d", n, 1 + 2 + LS); end
    n_chk++; if ({retry_cnt, fail, pll_reset} !== 6'd0) begin n_fail++; $display("FAIL lock_state got retry %0d fail %b prst %b want 0/0/0", retry_cnt, fail, pll_reset); end
  endtask

  task automatic test_lock_loss();
    int n;
    repeat (3) step();
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_sync1 got %b want 1", locked); end
    step();
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_sync2 got %b want 1", locked); end
    step();
    n_chk++; if ({locked, pll_reset, profile_idx, retry_cnt} !== {1'b0, 1'b1, 2'd0, 4'd0}) begin
      n_fail++; $display("FAIL loss_rst got lk %b prst %b prof %0d retry %0d want 0/1/0/0", locked, pll_reset, profile_idx, retry_cnt); end
    n = 3;
    while (!locked && n < 60) begin step(); n++; end
    n_chk++; if (n != 16) begin n_fail++; $display("FAIL relock got %0d want 16", n); end
`ifdef PLL_ADDA_LOCK_LOSS_CNT_EN
    n_chk++; if (lock_loss_cnt !== 8'd1) begin n_fail++; $display("FAIL loss_cnt got %0d want 1", lock_loss_cnt); end
`endif
  endtask

  task automatic test_toggle();
    int low_len, cyc;
    logic seen_low, bad_lock;
    pll_lock = 1'b1; restart = 1'b1;
    step();
    restart = 1'b0;
    low_len = 0; seen_low = 1'b0; bad_lock = 1'b0;
    for (cyc = 0; cyc < 300; cyc++) begin
      pll_lock = ((cyc % 7) != 6);
      step();
      if (locked) bad_lock = 1'b1;
      if (!pll_reset) begin low_len++; seen_low = 1'b1; end
      else if (seen_low) break;
    end
    n_chk++; if (bad_lock !== 1'b0) begin n_fail++; $display("FAIL toggle_locked got 1 want 0"); end
    n_chk++; if (low_len < LT || low_len > LT + 2) begin n_fail++; $display("FAIL toggle_timeout got %0d want %0d..%0d", low_len, LT, LT + 2); end
    n_chk++; if ({profile_idx, retry_cnt} !== {2'd1, 4'd1}) begin n_fail++; $display("FAIL toggle_adv got prof %0d retry %0d want 1/1", profile_idx, retry_cnt); end
  endtask

  task automatic test_fail();
    int ev;
    logic prev, lf_pend;
    logic [10:0] exp_lf;
    pll_lock = 1'b0; restart = 1'b1;
    step();
    restart = 1'b0;
    n_chk++; if ({pll_reset, fail, profile_idx, retry_cnt} !== {1'b1, 1'b0, 2'd0, 4'd0}) begin
      n_fail++; $display("FAIL fail_start got prst %b fail %b prof %0d retry %0d want 1/0/0/0", pll_reset, fail, profile_idx, retry_cnt); end
    ev = 0; lf_pend = 1'b0;
    for (int c = 0; c < 600; c++) begin
      prev = pll_reset;
      step();
      if (!prev && pll_reset) begin
        ev++;
        n_chk++; if ({retry_cnt, profile_idx, fail, locked} !== {4'(ev), 2'(ev), 1'(ev == MR), 1'b0}) begin
          n_fail++; $display("FAIL timeout%0d got retry %0d prof %0d fail %b lk %b", ev, retry_cnt, profile_idx, fail, locked); end
        lf_pend = 1'b1;
      end else if (lf_pend) begin
        case (ev)
          1:       exp_lf = {6'd24, 3'd3, 2'd0};
          2:       exp_lf = {6'd32, 3'd4, 2'd1};
          default: exp_lf = {6'd8,  3'd1, 2'd0};
        endcase
        n_chk++; if ({icpsel, lpfres, lpfcap} !== exp_lf) begin
          n_fail++; $display("FAIL lf%0d got %0d/%0d/%0d want %0d/%0d/%0d", ev, icpsel, lpfres, lpfcap, exp_lf[10:5], exp_lf[4:2], exp_lf[1:0]); end
        lf_pend = 1'b0;
        if (ev == MR) break;
      end
    end
    n_chk++; if (ev != MR) begin n_fail++; $display("FAIL fail_events got %0d want %0d", ev, MR); end
    repeat (5) step();
    n_chk++; if ({fail, pll_reset, locked, retry_cnt} !== {1'b1, 1'b1, 1'b0, 4'd3}) begin
      n_fail++; $display("FAIL fail_hold got fail %b prst %b lk %b retry %0d want 1/1/0/3", fail, pll_reset, locked, retry_cnt); end
  endtask

  task automatic test_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
    n_chk++; if ({fail, retry_cnt, profile_idx, pll_reset, locked} !== {1'b0, 4'd0, 2'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL restart got fail %b retry %0d prof %0d prst %b lk %b want 0/0/0/1/0", fail, retry_cnt, profile_idx, pll_reset, locked); end
    step();
    n_chk++; if ({icpsel, lpfres, lpfcap} !== {6'd16, 3'd2, 2'd0}) begin n_fail++; $display("FAIL restart_lf got %0d/%0d/%0d want 16/2/0", icpsel, lpfres, lpfcap); end
`ifdef PLL_ADDA_LOCK_LOSS_CNT_EN
    n_chk++; if (lock_loss_cnt !== 8'd1) begin n_fail++; $display("FAIL restart_loss got %0d want 1", lock_loss_cnt); end
`endif
    repeat (8) step();
    reset = 1'b1; restart = 1'b1;
    step();
    n_chk++; if ({pll_reset, locked, fail, retry_cnt, profile_idx} !== {1'b1, 1'b0, 1'b0, 4'd0, 2'd0}) begin
      n_fail++; $display("FAIL rst_restart got prst %b lk %b fail %b retry %0d prof %0d", pll_reset, locked, fail, retry_cnt, profile_idx); end
    n_chk++; if ({icpsel, lpfres, lpfcap} !== {6'd16, 3'd2, 2'd0}) begin n_fail++; $display("FAIL rst_restart_lf got %0d/%0d/%0d want 16/2/0", icpsel, lpfres, lpfcap); end
`ifdef PLL_ADDA_LOCK_LOSS_CNT_EN
    n_chk++; if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_loss got %0d want 0", lock_loss_cnt); end
`endif
    reset = 1'b0; restart = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_lock();
    test_lock_loss();
    test_toggle();
    test_fail();
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
